// File: rtl/sim_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sim_test_ctrl
//  Description : Simulation-harness test controller. Sequences the core reset
//                after harness reset, watches the core store port for the
//                tohost termination write and signature-region writes, and
//                runs a cycle watchdog. Reports done/pass/timeout/test_num.
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_test_ctrl #(
    parameter int unsigned          ADDR_W       = 32,
    parameter int unsigned          DATA_W       = 32,
    parameter int unsigned          RESET_CYCLES = 4,
    parameter int unsigned          MAX_CYCLES   = 100000,
    parameter int unsigned          CNT_W        = 32,
    parameter logic [ADDR_W-1:0]    TOHOST_ADDR  = 32'h0000_1000,
    parameter logic [ADDR_W-1:0]    SIG_BEGIN    = 32'h0000_2000,
    parameter logic [ADDR_W-1:0]    SIG_END      = 32'h0000_2100,
    parameter int unsigned          SIG_IDX_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    core_reset,
    input  logic                    mem_we,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_wdata,
    output logic                    sig_valid,
    output logic [SIG_IDX_W-1:0]    sig_index,
    output logic [DATA_W-1:0]       sig_data,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [DATA_W-2:0]       test_num,
    output logic [CNT_W-1:0]        cycle_count
);

    // Byte-offset bits below word granularity, dropped when forming the index
    localparam int unsigned         c_byte_shift = $clog2(DATA_W / 8);
    localparam logic [7:0]          c_hold_last  = 8'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_wd_last    = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_hold_cnt;

    logic               w_tohost;
    logic               w_sig_hit;
    logic               w_wd_expire;
    logic [ADDR_W-1:0]  w_sig_off;

    // Store decode; only meaningful while the FSM is in RUN
    always_comb begin
        w_tohost    = mem_we && (mem_addr == TOHOST_ADDR);
        w_sig_hit   = mem_we && (mem_addr >= SIG_BEGIN) && (mem_addr < SIG_END);
        w_wd_expire = (cycle_count == c_wd_last);
        w_sig_off   = mem_addr - SIG_BEGIN;
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= 8'd0;
            core_reset  <= 1'b1;
            sig_valid   <= 1'b0;
            sig_index   <= '0;
            sig_data    <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            test_num    <= '0;
            cycle_count <= '0;
        end else begin
            // Capture pulse lasts one cycle unless re-armed below
            sig_valid <= 1'b0;
            case (r_state)
                S_HOLD: begin
                    // core_reset drops one edge after entering RUN, giving
                    // exactly RESET_CYCLES high edges after release
                    core_reset <= 1'b1;
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    if (r_hold_cnt == c_hold_last) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    core_reset  <= 1'b0;
                    cycle_count <= cycle_count + CNT_W'(1);
                    if (w_sig_hit) begin
                        sig_valid <= 1'b1;
                        sig_index <= SIG_IDX_W'(w_sig_off >> c_byte_shift);
                        sig_data  <= mem_wdata;
                    end
                    // tohost beats a watchdog expiry in the same cycle
                    if (w_tohost) begin
                        r_state    <= S_DONE;
                        core_reset <= 1'b1;
                        done       <= 1'b1;
                        pass       <= (mem_wdata == DATA_W'(1));
                        timeout    <= 1'b0;
                        test_num   <= mem_wdata[DATA_W-1:1];
                    end else if (w_wd_expire) begin
                        r_state    <= S_DONE;
                        core_reset <= 1'b1;
                        done       <= 1'b1;
                        pass       <= 1'b0;
                        timeout    <= 1'b1;
                        test_num   <= '0;
                    end
                end
                S_DONE: begin
                    // Terminal: keep the core frozen, hold all status
                    core_reset <= 1'b1;
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sim_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_test_ctrl
//  Description : Scoreboard bench for sim_test_ctrl. The driver plans each run
//                as a list of stores per RUN cycle, derives the terminating
//                cycle from the test rules and queues the expected outputs;
//                a monitor pops and compares one entry per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_test_ctrl;

    localparam int          RC     = 4;
    localparam int          MAXC   = 20;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam logic [31:0] SB     = 32'h0000_2000;
    localparam logic [31:0] SE     = 32'h0000_2100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        core_reset;
    logic        sig_valid;
    logic [7:0]  sig_index;
    logic [31:0] sig_data;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [30:0] test_num;
    logic [31:0] cycle_count;

    sim_test_ctrl #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .RESET_CYCLES (RC),
        .MAX_CYCLES   (MAXC),
        .CNT_W        (32),
        .TOHOST_ADDR  (TOHOST),
        .SIG_BEGIN    (SB),
        .SIG_END      (SE),
        .SIG_IDX_W    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_reset  (core_reset),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .sig_valid   (sig_valid),
        .sig_index   (sig_index),
        .sig_data    (sig_data),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .test_num    (test_num),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        core_reset;
        logic        sig_valid;
        logic [7:0]  sig_index;
        logic [31:0] sig_data;
        logic        done;
        logic        pass;
        logic        timeout;
        logic [30:0] test_num;
        logic [31:0] cycle_count;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    obs_t mon_e;
    obs_t mon_a;

    // Planned stores, indexed by RUN cycle number k (1-based)
    logic        p_we   [0:63];
    logic [31:0] p_addr [0:63];
    logic [31:0] p_data [0:63];

    function automatic obs_t observe();
        obs_t o;
        o.core_reset  = core_reset;
        o.sig_valid   = sig_valid;
        o.sig_index   = sig_index;
        o.sig_data    = sig_data;
        o.done        = done;
        o.pass        = pass;
        o.timeout     = timeout;
        o.test_num    = test_num;
        o.cycle_count = cycle_count;
        return o;
    endfunction

    // Monitor: one expected entry per clock edge, sampled 1 time unit later
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = observe();
            vectors++;
            if (mon_a !== mon_e) begin
                miscompares++;
                $display("FAIL cycle t=%0t actual=%h required=%h (cr,sv,idx,data,done,pass,to,tn,cnt)",
                         $time, mon_a, mon_e);
            end
        end
    end

    task automatic check_reset(input string name);
        obs_t e;
        obs_t a;
        e = '0;
        e.core_reset = 1'b1;
        a = observe();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, a, e);
        end
    endtask

    function automatic logic [31:0] rand_addr(input bit allow_tohost);
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0, 1: a = SB + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            2:    a = SE;
            3:    a = SB - 32'd4;
            4:    a = SE - 32'd1;
            5:    a = SB;
            6:    a = allow_tohost ? TOHOST : 32'h0000_3000;
            default: a = $urandom() & 32'h0000_FFFC;
        endcase
        if (!allow_tohost && a == TOHOST) a = 32'h0000_4000;
        return a;
    endfunction

    task automatic plan_random();
        for (int k = 0; k < 64; k++) begin
            p_we[k]   = 1'($urandom_range(0, 1));
            p_addr[k] = rand_addr(1'b0);
            p_data[k] = $urandom();
        end
    endtask

    // One complete run: reset, HOLD, RUN until termination (+3 DONE cycles),
    // or an asynchronous reset at RUN cycle er when er > 0.
    task automatic execute(input int term_k, input logic [31:0] term_val, input int er);
        bit          th;
        int          t_end;
        int          last;
        int          k;
        logic [7:0]  li;
        logic [31:0] ld;
        obs_t        e;

        th    = (term_k != 0) && (term_k <= MAXC);
        t_end = th ? term_k : MAXC;
        for (int j = t_end + 1; j < 64; j++) begin
            if (j != term_k) p_addr[j] = rand_addr(1'b1);
        end
        if (term_k != 0) begin
            p_we[term_k]   = 1'b1;
            p_addr[term_k] = TOHOST;
            p_data[term_k] = term_val;
        end
        if (er > 0) begin
            p_we[er]   = 1'b1;
            p_addr[er] = SB + 32'($urandom_range(0, 63) * 4);
        end
        last = (er > 0) ? er : t_end + 3;

        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset("reset_entry");
        @(negedge clk);
        mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'd1;
        @(negedge clk);
        reset = 1'b1;
        li = '0;
        ld = '0;
        for (int ed = 1; ed <= RC + last; ed++) begin
            e = '0;
            if (ed <= RC) begin
                mem_we    = 1'($urandom_range(0, 1));
                mem_addr  = rand_addr(1'b1);
                mem_wdata = $urandom();
                e.core_reset = 1'b1;
            end else begin
                k = ed - RC;
                mem_we    = p_we[k];
                mem_addr  = p_addr[k];
                mem_wdata = p_data[k];
                e.cycle_count = 32'((k < t_end) ? k : t_end);
                e.core_reset  = (k >= t_end);
                if (k >= t_end) begin
                    e.done     = 1'b1;
                    e.pass     = th && (term_val == 32'd1);
                    e.timeout  = !th;
                    e.test_num = th ? term_val[31:1] : 31'd0;
                end
                if (k <= t_end && p_we[k] && p_addr[k] >= SB && p_addr[k] < SE) begin
                    e.sig_valid = 1'b1;
                    li = 8'((p_addr[k] - SB) / 4);
                    ld = p_data[k];
                end
            end
            e.sig_index = li;
            e.sig_data  = ld;
            exp_q.push_back(e);
            @(posedge clk);
            if (er > 0 && ed == RC + er) begin
                #2 reset = 1'b0;
                #1 check_reset("async_reset");
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int tk;
        int te;
        int er;
        logic [31:0] tv;

        repeat (2) @(negedge clk);

        // Signature region boundaries, then pass at cycle 12
        plan_random();
        for (int j = 1; j <= 11; j++) p_we[j] = 1'b0;
        p_we[1] = 1'b1; p_addr[1] = 32'h2000; p_data[1] = 32'hAAAA_0001;
        p_we[2] = 1'b1; p_addr[2] = 32'h2004; p_data[2] = 32'hBBBB_0002;
        p_we[4] = 1'b1; p_addr[4] = 32'h20FC; p_data[4] = 32'h0000_CCCC;
        p_we[6] = 1'b1; p_addr[6] = 32'h2100; p_data[6] = 32'h0000_DDDD;
        p_we[8] = 1'b1; p_addr[8] = 32'h1FFC; p_data[8] = 32'h0000_EEEE;
        execute(12, 32'd1, 0);

        // Pass, fail, watchdog, priority at expiry, tohost after expiry
        plan_random(); execute(3, 32'd1, 0);
        plan_random(); execute(5, 32'd7, 0);
        plan_random(); execute(0, 32'd0, 0);
        plan_random(); execute(MAXC, 32'd1, 0);
        plan_random(); execute(MAXC + 1, 32'd1, 0);
        plan_random(); execute(1, 32'd0, 0);

        // Asynchronous reset mid-run with a capture pulse showing
        plan_random(); execute(15, 32'd1, 6);

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            plan_random();
            tk = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 24));
            tv = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom();
            te = (tk != 0 && tk <= MAXC) ? tk : MAXC;
            er = ($urandom_range(0, 4) == 0 && te >= 2) ? int'($urandom_range(1, te - 1)) : 0;
            execute(tk, tv, er);
        end

        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: actual=%0d unconsumed entries required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sim_test_ctrl.md
Name: sim_test_ctrl

Overview:
- Synthesisable test-control block instantiated beside `top` in the simulation harness.
- Sequences the core's reset after harness reset releases.
- Watches the core's data-memory store port:
  - terminates the run on a store to the tohost address;
  - captures stores into the signature region as an indexed stream the harness writes to the signature file;
  - enforces a cycle-count watchdog.
- Reports done/pass/fail/timeout and the failing test number.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, store data width. Must be a multiple of 8.
- RESET_CYCLES, 4, cycles core_reset is held after reset deasserts. Legal range 1..255.
- MAX_CYCLES, 100000, watchdog limit on RUN cycles.
- CNT_W, 32, cycle_count width. Must satisfy 2^CNT_W > MAX_CYCLES.
- TOHOST_ADDR, 32'h0000_1000, word address that ends the test.
- SIG_BEGIN, 32'h0000_2000, first byte address of the signature region (inclusive). Word aligned.
- SIG_END, 32'h0000_2100, end byte address of the signature region (exclusive). Word aligned, greater than SIG_BEGIN.
- SIG_IDX_W, 8, signature word index width. Must satisfy 2^SIG_IDX_W >= (SIG_END-SIG_BEGIN)/(DATA_W/8).

Ports:
- clk, input, 1, single clock; all state is updated on its rising edge.
- reset, input, 1, asynchronous, active-low.
- core_reset, output, 1, active-high reset to the core/top.
- mem_we, input, 1, core store strobe; one store per cycle when high.
- mem_addr, input, ADDR_W, store byte address.
- mem_wdata, input, DATA_W, store data.
- sig_valid, output, 1, one-cycle pulse: signature word captured.
- sig_index, output, SIG_IDX_W, word index = (mem_addr-SIG_BEGIN)/(DATA_W/8).
- sig_data, output, DATA_W, captured store data.
- done, output, 1, sticky: test ended by any cause.
- pass, output, 1, sticky: tohost store with value 1.
- timeout, output, 1, sticky: watchdog expired.
- test_num, output, DATA_W-1, mem_wdata[DATA_W-1:1] of the terminating tohost store.
- cycle_count, output, CNT_W, count of RUN cycles.

Behaviour:
- Reset values while reset=0:
  - state=HOLD, hold counter=0, core_reset=1;
  - sig_valid=0, sig_index=0, sig_data=0;
  - done=0, pass=0, timeout=0, test_num=0, cycle_count=0.
- Reset is asynchronous assert, synchronous deassert as seen by the flops. Reset mid-RUN or mid-DONE returns everything to the reset values immediately.
- HOLD:
  - core_reset=1; hold counter increments each cycle.
  - When the counter reaches RESET_CYCLES-1, next state is RUN.
  - core_reset is low from the first RUN cycle, so it is high for exactly RESET_CYCLES clk edges after release.
  - mem_* inputs are ignored in HOLD.
- RUN:
  - cycle_count increments by 1 every cycle, including the terminating cycle.
  - Store decode applies only when mem_we=1; all outputs are registered, one cycle after the sampled store.
  - tohost: mem_addr==TOHOST_ADDR → next state DONE, done=1, test_num=mem_wdata[DATA_W-1:1], pass=(mem_wdata==1).
  - Signature: mem_we=1 and SIG_BEGIN<=mem_addr<SIG_END → sig_valid=1 next cycle with sig_index and sig_data. The low address bits below word granularity are ignored for the index.
  - The SIG_END-exact address and addresses below SIG_BEGIN produce no capture.
  - sig_valid is 0 in every cycle without a qualifying store; sig_index and sig_data hold their last value.
  - Watchdog: when cycle_count==MAX_CYCLES-1 and no tohost store is sampled that cycle → DONE with done=1, timeout=1, pass=0, test_num=0.
  - Simultaneous tohost store and watchdog expiry: tohost wins, timeout=0.
- DONE:
  - Terminal state; exits only via reset.
  - core_reset is driven back to 1 to freeze the core.
  - cycle_count stops; done, pass, timeout and test_num hold.
  - Further stores are ignored; no sig_valid.
- Invariants:
  - pass and timeout are never both 1.
  - done=0 implies pass=0 and timeout=0.
- Arithmetic: all address compares are unsigned, full ADDR_W width. cycle_count does not wrap before MAX_CYCLES, guaranteed by the CNT_W rule.

Test Plan:
- Reset sequencing, RESET_CYCLES=4: release reset at cycle 0 → core_reset=1 for edges 1–4, 0 from edge 5; cycle_count=0 until RUN, then 1, 2, 3…
- Pass: in RUN, store 32'h1 to 32'h1000 → next cycle done=1, pass=1, timeout=0, test_num=0, core_reset=1; cycle_count frozen.
- Fail: store 32'h0000_0007 to 32'h1000 → done=1, pass=0, test_num=3.
- Signature: stores 32'hAAAA_0001@2000, 32'hBBBB_0002@2004, 32'hCCCC@20FC, 32'hDDDD@2100, 32'hEEEE@1FFC →
  - sig_valid pulses three times: (0, AAAA_0001), (1, BBBB_0002), (63, 0000_CCCC);
  - no pulses for 2100 or 1FFC;
  - sig_valid=0 in non-store cycles.
- Watchdog and priority, MAX_CYCLES=20:
  - no tohost store → done=1, timeout=1 after cycle_count reaches 20;
  - second run with tohost store of 1 on the same cycle as expiry → pass=1, timeout=0.
- Reset mid-run: assert reset asynchronously between edges during RUN with a sig_valid pulse pending → all outputs return to reset values immediately; after release the HOLD sequence restarts and cycle_count restarts at 0.
